// File: rtl/regfile_ext.sv
// Register file with hardwired zero, external-input and sticky edge-capture registers,
// plus a flattened export window. Define REGFILE_SYNC_EN for a two-stage input synchronizer.
module regfile_ext #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_REGS     = 32,
  parameter int EXT_REG      = 29,
  parameter int EDGE_REG     = 28,
  parameter int EXPORT_BASE  = 10,
  parameter int EXPORT_COUNT = 14
) (
  input  logic                               clock,
  input  logic                               ctrl_reset,
  input  logic                               ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]              ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]              data_writeReg,
  input  logic [ADDR_WIDTH-1:0]              ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0]              ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0]              external_inputs,
  output logic [DATA_WIDTH-1:0]              data_readRegA,
  output logic [DATA_WIDTH-1:0]              data_readRegB,
  output logic [EXPORT_COUNT*DATA_WIDTH-1:0] export_bus,
  output logic                               ext_event
);

  if (EXT_REG == EDGE_REG || EXT_REG == 0 || EDGE_REG == 0 ||
      EXT_REG >= NUM_REGS || EDGE_REG >= NUM_REGS || NUM_REGS > 2**ADDR_WIDTH) begin : g_bad_cfg
    $error("regfile_ext: illegal EXT_REG/EDGE_REG/NUM_REGS configuration");
  end

  localparam logic [ADDR_WIDTH-1:0] EDGE_IDX = ADDR_WIDTH'(EDGE_REG);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] ext_src;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] clr;

`ifdef REGFILE_SYNC_EN
  logic [DATA_WIDTH-1:0] sync1_q;
  logic [DATA_WIDTH-1:0] sync1_d;

  always_comb begin
    sync1_d = external_inputs;
  end

  always_ff @(negedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) sync1_q <= '0;
    else             sync1_q <= sync1_d;
  end

  assign ext_src = sync1_q;
`else
  assign ext_src = external_inputs;
`endif

  // A rise is judged against the value EXT_REG is about to be replaced with.
  assign rise = ext_src & ~regs_q[EXT_REG];
  assign clr  = (ctrl_writeEnable && ctrl_writeReg == EDGE_IDX) ? data_writeReg : '0;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    regs_d[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (i != EXT_REG && i != EDGE_REG &&
          ctrl_writeEnable && ctrl_writeReg == ADDR_WIDTH'(i)) begin
        regs_d[i] = data_writeReg;
      end
    end
    regs_d[EXT_REG]  = ext_src;
    regs_d[EDGE_REG] = (regs_q[EDGE_REG] & ~clr) | rise;
  end

  always_ff @(negedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Index 0 and out-of-range indices never match, so they read as zero.
  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ctrl_readRegA == ADDR_WIDTH'(i)) data_readRegA = regs_q[i];
      if (ctrl_readRegB == ADDR_WIDTH'(i)) data_readRegB = regs_q[i];
    end
  end

  assign ext_event = |regs_q[EDGE_REG];

  for (genvar gi = 0; gi < EXPORT_COUNT; gi++) begin : g_export
    localparam int IDX = EXPORT_BASE + gi;
    if (IDX < NUM_REGS) begin : g_in
      assign export_bus[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[IDX];
    end else begin : g_out
      assign export_bus[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end

endmodule

// File: tb/tb_regfile_ext.sv
// Scoreboard bench for regfile_ext: a default instance plus a NUM_REGS=24 instance
// sharing the same stimulus, both checked against a behavioural model.
module tb_regfile_ext;

`ifdef REGFILE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clock;
  logic         ctrl_reset;
  logic         ctrl_writeEnable;
  logic [4:0]   ctrl_writeReg;
  logic [31:0]  data_writeReg;
  logic [4:0]   ctrl_readRegA;
  logic [4:0]   ctrl_readRegB;
  logic [31:0]  external_inputs;
  logic [31:0]  data_readRegA, data_readRegB;
  logic [447:0] export_bus;
  logic         ext_event;
  logic [31:0]  s_rdA, s_rdB;
  logic [447:0] s_export;
  logic         s_event;

  regfile_ext dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .external_inputs(external_inputs), .data_readRegA(data_readRegA),
    .data_readRegB(data_readRegB), .export_bus(export_bus), .ext_event(ext_event)
  );

  regfile_ext #(.NUM_REGS(24), .EXT_REG(21), .EDGE_REG(20)) dut_small (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .external_inputs(external_inputs), .data_readRegA(s_rdA),
    .data_readRegB(s_rdB), .export_bus(s_export), .ext_event(s_event)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model, one slot per instance.
  int NR[2] = '{32, 24};
  int ER[2] = '{29, 21};
  int DR[2] = '{28, 20};
  logic [31:0] m_regs [2][32];
  logic [31:0] m_sync [2];

  task automatic m_clear();
    for (int d = 0; d < 2; d++) begin
      m_sync[d] = '0;
      for (int r = 0; r < 32; r++) m_regs[d][r] = '0;
    end
  endtask

  task automatic m_step(input int d, input bit we, input int wr,
                        input logic [31:0] wd, input logic [31:0] ext);
    logic [31:0] src, rise, clr, nedge;
`ifdef REGFILE_SYNC_EN
    src = m_sync[d];
`else
    src = ext;
`endif
    rise  = src & ~m_regs[d][ER[d]];
    clr   = (we && wr == DR[d]) ? wd : 32'h0;
    nedge = (m_regs[d][DR[d]] & ~clr) | rise;
    if (we && wr != 0 && wr != ER[d] && wr != DR[d] && wr < NR[d]) m_regs[d][wr] = wd;
    m_regs[d][ER[d]] = src;
    m_regs[d][DR[d]] = nedge;
    m_sync[d] = ext;
  endtask

  function automatic logic [31:0] m_read(input int d, input int a);
    return (a == 0 || a >= NR[d]) ? 32'h0 : m_regs[d][a];
  endfunction

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      0: return data_readRegA;
      1: return data_readRegB;
      2: return {31'b0, ext_event};
      3: return export_bus[31:0];
      4: return export_bus[13*32 +: 32];
      5: return s_rdA;
      6: return s_rdB;
      7: return {31'b0, s_event};
      default: return s_export[13*32 +: 32];
    endcase
  endfunction

  function automatic exp_t mk(input string tag, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    return e;
  endfunction

  // Called just after a rising edge; drives one falling-edge transaction.
  task automatic cycle(input string tag, input bit we, input int wr, input logic [31:0] wd,
                       input int ra, input int rb);
    exp_t e;
    ctrl_writeEnable = we;
    ctrl_writeReg    = 5'(wr);
    data_writeReg    = wd;
    ctrl_readRegA    = 5'(ra);
    ctrl_readRegB    = 5'(rb);
    for (int d = 0; d < 2; d++) m_step(d, we, wr, wd, external_inputs);
    sb.push_back(mk({tag, ".rdA"}, 0, m_read(0, ra)));
    sb.push_back(mk({tag, ".rdB"}, 1, m_read(0, rb)));
    sb.push_back(mk({tag, ".event"}, 2, {31'b0, |m_regs[0][28]}));
    sb.push_back(mk({tag, ".exp0"}, 3, m_regs[0][10]));
    sb.push_back(mk({tag, ".exp13"}, 4, m_regs[0][23]));
    sb.push_back(mk({tag, ".s_rdA"}, 5, m_read(1, ra)));
    sb.push_back(mk({tag, ".s_rdB"}, 6, m_read(1, rb)));
    sb.push_back(mk({tag, ".s_event"}, 7, {31'b0, |m_regs[1][20]}));
    sb.push_back(mk({tag, ".s_exp13"}, 8, m_regs[1][23]));
    $display("txn %s we=%0d wr=%0d wd=%h ra=%0d rb=%0d ext=%h", tag, we, wr, wd, ra, rb,
             external_inputs);
    @(negedge clock);
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind), e.exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    int addrs[5] = '{0, 10, 23, 28, 29};
    for (int i = 0; i < 5; i++) begin
      ctrl_readRegA = 5'(addrs[i]);
      #1;
      check($sformatf("%s.rd%0d", tag, addrs[i]), data_readRegA, 32'h0);
    end
    check({tag, ".export_or"}, {31'b0, |export_bus}, 32'h0);
    check({tag, ".event"}, {31'b0, ext_event}, 32'h0);
    check({tag, ".s_export_or"}, {31'b0, |s_export}, 32'h0);
  endtask

  initial begin
    ctrl_reset = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg = '0;
    data_writeReg = '0;
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;
    external_inputs = '0;
    m_clear();
    #1;
    reset_checks("por");
    @(posedge clock); #1;
    ctrl_reset = 1'b1;

    cycle("wr_zero", 1, 0, 32'hDEADBEEF, 0, 0);
    cycle("wr_r10", 1, 10, 32'h00000123, 10, 10);
    cycle("wr_r23", 1, 23, 32'hFFFF0000, 23, 10);
    cycle("wr_oor30", 1, 30, 32'h00000077, 30, 23);

    external_inputs = 32'h5;
    cycle("ext_wr_ign", 1, 29, 32'h0000AAAA, 29, 28);
    for (int i = 0; i < LAT + 1; i++) cycle("ext_lat", 0, 0, 0, 29, 28);
    cycle("edge_clr_all", 1, 28, 32'hFFFFFFFF, 28, 29);

    external_inputs = 32'hD;
    cycle("pulse_hi", 0, 0, 0, 28, 29);
    external_inputs = 32'h5;
    for (int i = 0; i < LAT + 2; i++) cycle("pulse_hold", 0, 0, 0, 28, 29);
    cycle("edge_clr8", 1, 28, 32'h00000008, 28, 29);
    cycle("edge_idle", 0, 0, 0, 28, 29);

    external_inputs = 32'h4;
    for (int i = 0; i < LAT + 1; i++) cycle("bit0_low", 0, 0, 0, 28, 29);
    external_inputs = 32'h5;
    for (int i = 0; i < LAT - 1; i++) cycle("bit0_wait", 0, 0, 0, 28, 29);
    cycle("set_wins", 1, 28, 32'h00000001, 28, 29);
    cycle("clr_bit0", 1, 28, 32'h00000001, 28, 29);

    for (int i = 0; i < 24; i++) begin
      if (($urandom % 4) == 0) external_inputs = $urandom;
      cycle("rand", 1'($urandom), int'($urandom_range(0, 31)), $urandom,
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end

    #2;
    ctrl_reset = 1'b0;
    m_clear();
    #1;
    reset_checks("mid_rst");
    @(posedge clock); #1;
    ctrl_reset = 1'b1;
    cycle("post_rst", 1, 12, 32'h0BADF00D, 12, 29);
    cycle("post_rst2", 0, 0, 0, 12, 28);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_ext.md
Name: regfile_ext

Overview:
Parametrised successor to the processor register file. It provides two combinational read ports, one write port, a hardwired zero register, and an external-input register refreshed every cycle. It adds two features: a sticky edge-capture register with write-1-to-clear semantics, and a flattened export window that drives game-state registers (ball, paddles, notes, info) straight to display and audio logic. It sits inside the processor core between the writeback stage and the operand-fetch stage.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width
NUM_REGS, 32, implemented registers, indices 0..NUM_REGS-1; must be <= 2**ADDR_WIDTH
EXT_REG, 29, index of the read-only external-input register
EDGE_REG, 28, index of the sticky rising-edge capture register
EXPORT_BASE, 10, first register index exported on export_bus
EXPORT_COUNT, 14, number of consecutive registers exported

Ports:
clock  input  1  system clock; all state updates on the falling edge
ctrl_reset  input  1  asynchronous, active-low reset
ctrl_writeEnable  input  1  write strobe
ctrl_writeReg  input  ADDR_WIDTH  write index
data_writeReg  input  DATA_WIDTH  write data
ctrl_readRegA  input  ADDR_WIDTH  read index A
ctrl_readRegB  input  ADDR_WIDTH  read index B
external_inputs  input  DATA_WIDTH  raw asynchronous inputs (buttons, guitar frets)
data_readRegA  output  DATA_WIDTH  read data A
data_readRegB  output  DATA_WIDTH  read data B
export_bus  output  EXPORT_COUNT*DATA_WIDTH  registers EXPORT_BASE..EXPORT_BASE+EXPORT_COUNT-1; slice k = register EXPORT_BASE+k
ext_event  output  1  high while EDGE_REG is non-zero

Behaviour:
- Reset (ctrl_reset=0): all registers, synchronizer flops and EDGE_REG clear to 0 immediately, independent of clock. export_bus=0, ext_event=0, and reads return 0 during reset.
- Read ports: purely combinational mux with no tristates. Index 0 or any index >= NUM_REGS reads 0.
- Write timing: committed on the falling edge when ctrl_writeEnable=1. Data written in the first half of a cycle is therefore visible on the read ports in the second half of that cycle.
- Ignored writes: writes to index 0, EXT_REG, or any index >= NUM_REGS are dropped silently.
- General registers: every index other than 0, EXT_REG and EDGE_REG is an ordinary read/write register.
- EXT_REG: loads the synchronized external_inputs on every falling edge. It is read-only.
- Synchronizer path: external_inputs -> sync1 -> EXT_REG, two falling edges of latency (sync1 is omitted when the option below is off).
- EDGE_REG next-state per bit: (EDGE_REG & ~clr) | rise.
  - rise = sync1 & ~EXT_REG, i.e. a 0->1 transition about to be loaded into EXT_REG.
  - clr = data_writeReg when ctrl_writeEnable=1 and ctrl_writeReg=EDGE_REG; otherwise 0.
  - When a new rise and a clear hit the same bit in the same edge, the set wins and the bit stays 1.
  - CPU writes of 0-bits leave EDGE_REG bits unchanged.
- ext_event = |EDGE_REG, registered by construction (no extra delay).
- export_bus: mirrors register contents after each falling-edge update. If an exported index equals EXT_REG or EDGE_REG, the export shows that register's value. Exported indices >= NUM_REGS drive 0.
- Elaboration checks: EXT_REG != EDGE_REG, both nonzero and < NUM_REGS; otherwise a $error is raised.

Optional Feature:
REGFILE_SYNC_EN
- Defined: two-stage synchronizer as described, giving two falling edges of input latency.
- Undefined: sync1 is removed. EXT_REG loads external_inputs directly, and rise = external_inputs & ~EXT_REG, giving one falling edge of latency. Use this only when the inputs are already synchronous to clock.

Test Plan:
- Reset and zero register: drive ctrl_reset=0 mid-cycle, then release; write 0xDEADBEEF to reg 0 -> reads of reg 0 return 0, and all regs plus export_bus are 0 immediately after reset assertion.
- Write/read and export: write 0x00000123 to reg 10 and 0xFFFF0000 to reg 23 -> both read ports return the written values in the same cycle after the falling edge; export_bus slice 0 = 0x123, slice 13 = 0xFFFF0000.
- External input latency: external_inputs goes 0 -> 0x5 -> EXT_REG reads 0x5 after exactly 2 falling edges (1 with REGFILE_SYNC_EN undefined); a CPU write of 0xAAAA to EXT_REG is ignored.
- Edge capture: pulse input bit 3 high then low -> EDGE_REG=0x8 and ext_event=1, persisting after the input falls; writing 0x8 to EDGE_REG clears it and ext_event drops to 0.
- Set wins over clear: a rise on bit 0 coincides with a write of 0x1 to EDGE_REG -> EDGE_REG bit 0 remains 1.
- Out-of-range access: with NUM_REGS=24, write 0x77 to reg 30 and read it back -> returns 0; no other register changes.
